// File: rtl/shift_add_multiplier_pkg.sv
// Shared constants and state encoding for the shift-and-add multiplier.
package shift_add_multiplier_pkg;

    localparam int OP_W   = 5;          // operand width, fixed by the adder
    localparam int N_ITER = 5;          // one iteration per operand bit
    localparam int CNT_W  = 3;
    localparam int PROD_W = 2 * OP_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand/result bundle between the operand source and the multiplier.
interface shift_add_multiplier_if;
    import shift_add_multiplier_pkg::*;

    logic              start;
    logic [OP_W-1:0]   multiplicand;
    logic [OP_W-1:0]   multiplier;
    logic [PROD_W-1:0] product;
    logic              busy;
    logic              done;

    modport master (
        output start, multiplicand, multiplier,
        input  product, busy, done
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output product, busy, done
    );

endinterface

// File: rtl/shift_add_multiplier_adder.sv
// 5-bit ripple-carry adder; carry-in tied low.
module shift_add_multiplier_adder
    import shift_add_multiplier_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output logic [OP_W-1:0] s,
    output logic            cout
);

    logic [OP_W:0] c;

    assign c[0] = 1'b0;

    // Full-adder chain, one cell per bit
    for (genvar i = 0; i < OP_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[OP_W];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 5x5 unsigned shift-and-add multiplier: one adder pass per clock,
// 10-bit product registered after the fifth iteration.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    shift_add_multiplier_if.slave  bus
);

    // The adder is a fixed 5-bit block; any other width cannot be built.
    if (WIDTH != OP_W) begin : g_bad_width
        $error("shift_add_multiplier: WIDTH must be 5");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITER - 1);

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [OP_W-1:0]   acc;
    logic [OP_W-1:0]   m_reg;
    logic [OP_W-1:0]   q_reg;
    logic [PROD_W-1:0] product_r;

    logic [OP_W-1:0]   b_op;
    logic [OP_W-1:0]   sum;
    logic              cout;
    logic [OP_W-1:0]   acc_nxt;
    logic [OP_W-1:0]   q_nxt;

    // Addend is selected only from registered state, so the adder has no input path.
    assign b_op = q_reg[0] ? m_reg : '0;

    shift_add_multiplier_adder u_adder (
        .a    (acc),
        .b    (b_op),
        .s    (sum),
        .cout (cout)
    );

    // {cout, sum, q} shifted right by one; carry lands in acc MSB, sum LSB enters q MSB.
    assign acc_nxt = {cout, sum[OP_W-1:1]};
    assign q_nxt   = {sum[0], q_reg[OP_W-1:1]};

    // Control FSM plus datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            count     <= '0;
            acc       <= '0;
            m_reg     <= '0;
            q_reg     <= '0;
            product_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        m_reg <= bus.multiplicand;
                        q_reg <= bus.multiplier;
                        acc   <= '0;
                        count <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc   <= acc_nxt;
                    q_reg <= q_nxt;
                    count <= count + 1'b1;
                    if (count == LAST_CNT) begin
                        product_r <= {acc_nxt, q_nxt};
                        state     <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.product = product_r;
    assign bus.busy    = (state == S_RUN) || (state == S_DONE);
    assign bus.done    = (state == S_DONE);

endmodule
